vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port framebuffer RAM between two requesters: the GPU scan-out fetch (display) and the CPU/draw port.
- Display is the high-priority requester. A streak counter guarantees CPU forward progress.
- Sits between the gpu top level (pixel fetch feeding o_RGB) and the framebuffer block RAM.
- Drives the RAM command bus and routes read data back to the owning requester.

Parameters:
- ADDR_WIDTH, 17, framebuffer word address width (320x240 = 76800 words).
- DATA_WIDTH, 3, pixel word width (RGB 3-bit).
- MAX_DISPLAY_STREAK, 8, consecutive display grants allowed while the CPU waits; range 1..255.

Ports:
- i_Clock  in  1  system clock (100 MHz).
- i_Reset  in  1  asynchronous, active-high reset.
- i_Display_Request_Valid  in  1  display read request.
- i_Display_Request_Address  in  ADDR_WIDTH  display read address.
- o_Display_Request_Ready  out  1  display request accepted this cycle.
- o_Display_Read_Valid  out  1  display read data valid.
- o_Display_Read_Data  out  DATA_WIDTH  display read data.
- i_Cpu_Valid  in  1  CPU request.
- i_Cpu_Write_Enable  in  1  1 = write, 0 = read.
- i_Cpu_Address  in  ADDR_WIDTH  CPU address.
- i_Cpu_Write_Data  in  DATA_WIDTH  CPU write data.
- o_Cpu_Ready  out  1  CPU request accepted this cycle.
- o_Cpu_Read_Valid  out  1  CPU read data valid.
- o_Cpu_Read_Data  out  DATA_WIDTH  CPU read data.
- o_Ram_Enable  out  1  RAM access strobe.
- o_Ram_Write_Enable  out  1  RAM write strobe.
- o_Ram_Address  out  ADDR_WIDTH  RAM address.
- o_Ram_Write_Data  out  DATA_WIDTH  RAM write data.
- i_Ram_Read_Data  in  DATA_WIDTH  RAM read data; 1-cycle synchronous read latency.

Behaviour:
- Handshake:
  - Transfer occurs when valid && ready on a rising i_Clock edge.
  - Ready signals are combinational from the current-cycle valids and the streak counter.
  - At most one ready is high per cycle.
  - Requesters hold address and data stable until accepted.
- Grant rule (cycle N):
  - Only display valid: display granted.
  - Only CPU valid: CPU granted.
  - Both valid: display granted if Streak < MAX_DISPLAY_STREAK, otherwise CPU granted.
  - Neither valid: no grant.
- Streak counter, width ceil(log2(MAX_DISPLAY_STREAK+1)):
  - +1 on a display grant while i_Cpu_Valid = 1.
  - Cleared on any CPU grant.
  - Cleared in any cycle with i_Cpu_Valid = 0.
  - Saturates at MAX_DISPLAY_STREAK.
- RAM command, registered:
  - Accept at the end of cycle N drives o_Ram_Enable = 1, address, write data and write enable during cycle N+1.
  - Write enable comes from i_Cpu_Write_Enable for CPU grants and is always 0 for display grants.
  - Without a grant: o_Ram_Enable = 0 and o_Ram_Write_Enable = 0; o_Ram_Address and o_Ram_Write_Data hold their last values.
- Response routing:
  - A 2-stage owner tag pipeline (NONE/DISPLAY/CPU) tracks reads; CPU writes enqueue NONE.
  - o_X_Read_Valid = 1 in cycle N+2 (2 cycles after accept), one cycle wide.
  - o_X_Read_Data = i_Ram_Read_Data (combinational) while valid, otherwise 0.
  - No backpressure on responses; requesters must sink them.
- Throughput: one access per cycle; back-to-back grants from either or alternating owners are legal.
- Reset:
  - Asserting i_Reset immediately clears all outputs to 0, the streak counter to 0 and the tag pipeline to NONE.
  - Ready outputs are forced to 0 while reset is high.
  - Reads in flight at reset are dropped and never produce a read valid.
- Boundary cases:
  - Address 2^ADDR_WIDTH-1 passes through unchanged.
  - MAX_DISPLAY_STREAK = 1 gives strict alternation under contention.

Decomposition:
- Shared package gpu_pkg holds:
  - owner enum (OWNER_NONE, OWNER_DISPLAY, OWNER_CPU);
  - RAM_READ_LATENCY = 1;
  - framebuffer geometry constants (FRAME_WIDTH = 320, FRAME_HEIGHT = 240).
- One sub-module, vram_response_pipe:
  - takes an owner tag per accepted access;
  - shifts it through the latency stages;
  - drives both read-valid outputs and data muxing.
- Grant logic, streak counter and RAM command registers stay in vram_arbiter.

Test Plan:
- Reset: assert i_Reset mid-cycle with both valids high → every output is 0 before the next clock edge; after release, the first grant goes to display.
- Display read:
  - Stimulus: address 0x00010, RAM model holding 3'b110 at that address.
  - Cycle N+1: o_Ram_Enable = 1, o_Ram_Write_Enable = 0, o_Ram_Address = 0x00010.
  - Cycle N+2: o_Display_Read_Valid = 1 with data 3'b110; o_Cpu_Read_Valid stays 0.
- CPU write then read at 0x1FFFF:
  - Write data 3'b101 → o_Ram_Write_Enable = 1 for one cycle; no read valid.
  - Following CPU read → o_Cpu_Read_Valid = 1 two cycles after accept, data 3'b101.
- Contention (MAX_DISPLAY_STREAK = 8, both valids held high for 27 cycles) → grant pattern is 8 display then 1 CPU, repeated 3 times; o_Cpu_Ready is high on cycles 9, 18 and 27.
- Alternating owners:
  - Stimulus: D, C(read), D, C(read) on consecutive cycles at distinct addresses.
  - Response: read valids alternate display/CPU two cycles later; each carries its own address's data; the two valids never overlap.
- Reset in flight: CPU read accepted, i_Reset pulsed in the following cycle → no o_Cpu_Read_Valid ever appears for that read; the streak counter reads 0.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: response owner tags, RAM timing and framebuffer geometry.
package gpu_pkg;

  // Owner of an access travelling through the read-latency pipeline.
  typedef enum logic [1:0] {
    OWNER_NONE    = 2'd0,
    OWNER_DISPLAY = 2'd1,
    OWNER_CPU     = 2'd2
  } owner_e;

  // Block RAM returns read data one cycle after it samples the command.
  localparam int RAM_READ_LATENCY = 1;

  // Framebuffer geometry, one pixel per word.
  localparam int FRAME_WIDTH  = 320;
  localparam int FRAME_HEIGHT = 240;
  localparam int FRAME_WORDS  = FRAME_WIDTH * FRAME_HEIGHT;

  // Bits needed to count 0..max inclusive.
  function automatic int streak_width(input int max_streak);
    return $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/vram_response_pipe.sv
// Carries the owner of each accepted access through the RAM latency and
// steers the returning read data to the requester that asked for it.
module vram_response_pipe
  import gpu_pkg::*;
#(
  parameter int DATA_WIDTH = 3
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  owner_e                i_Tag,
  input  logic [DATA_WIDTH-1:0] i_Ram_Read_Data,
  output logic                  o_Display_Read_Valid,
  output logic [DATA_WIDTH-1:0] o_Display_Read_Data,
  output logic                  o_Cpu_Read_Valid,
  output logic [DATA_WIDTH-1:0] o_Cpu_Read_Data
);

  // One stage for the registered RAM command plus the RAM read latency.
  localparam int STAGES = RAM_READ_LATENCY + 1;

  owner_e tag_q [STAGES];
  owner_e tag_d [STAGES];

  // Shift the owner tag one stage per cycle; a new tag enters every cycle.
  always_comb begin
    tag_d[0] = i_Tag;
    for (int i = 1; i < STAGES; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Tag registers; reset drops everything in flight.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      for (int i = 0; i < STAGES; i++) begin
        tag_q[i] <= OWNER_NONE;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // Route RAM data to the owner of the last stage; non-owners see zero.
  always_comb begin
    o_Display_Read_Valid = (tag_q[STAGES-1] == OWNER_DISPLAY);
    o_Cpu_Read_Valid     = (tag_q[STAGES-1] == OWNER_CPU);
    o_Display_Read_Data  = o_Display_Read_Valid ? i_Ram_Read_Data : '0;
    o_Cpu_Read_Data      = o_Cpu_Read_Valid     ? i_Ram_Read_Data : '0;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Framebuffer RAM arbiter: display scan-out has priority, a streak counter
// bounds how long the CPU/draw port can be starved.
//
// Handshake: a request transfers on a rising i_Clock edge where its valid and
// ready are both high. Readies are combinational from this cycle's valids and
// the streak count, at most one is high, and both are low during reset.
// Requesters keep address/data stable until accepted. Responses have no
// backpressure: a read valid appears for exactly one cycle, two cycles after
// the accept.
module vram_arbiter
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH         = 17,
  parameter int DATA_WIDTH         = 3,
  parameter int MAX_DISPLAY_STREAK = 8
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Display_Request_Valid,
  input  logic [ADDR_WIDTH-1:0] i_Display_Request_Address,
  output logic                  o_Display_Request_Ready,
  output logic                  o_Display_Read_Valid,
  output logic [DATA_WIDTH-1:0] o_Display_Read_Data,
  input  logic                  i_Cpu_Valid,
  input  logic                  i_Cpu_Write_Enable,
  input  logic [ADDR_WIDTH-1:0] i_Cpu_Address,
  input  logic [DATA_WIDTH-1:0] i_Cpu_Write_Data,
  output logic                  o_Cpu_Ready,
  output logic                  o_Cpu_Read_Valid,
  output logic [DATA_WIDTH-1:0] o_Cpu_Read_Data,
  output logic                  o_Ram_Enable,
  output logic                  o_Ram_Write_Enable,
  output logic [ADDR_WIDTH-1:0] o_Ram_Address,
  output logic [DATA_WIDTH-1:0] o_Ram_Write_Data,
  input  logic [DATA_WIDTH-1:0] i_Ram_Read_Data
);

  localparam int STREAK_WIDTH = streak_width(MAX_DISPLAY_STREAK);
  localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(MAX_DISPLAY_STREAK);

  logic                    display_grant;
  logic                    cpu_grant;
  owner_e                  grant_tag;

  logic [STREAK_WIDTH-1:0] streak_q, streak_d;
  logic                    ram_en_q, ram_en_d;
  logic                    ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;

  // Grant: display wins unless the CPU has waited through a full streak.
  always_comb begin
    display_grant = !i_Reset && i_Display_Request_Valid &&
                    (!i_Cpu_Valid || (streak_q < STREAK_MAX));
    cpu_grant     = !i_Reset && i_Cpu_Valid && !display_grant;
    o_Display_Request_Ready = display_grant;
    o_Cpu_Ready             = cpu_grant;
    if (display_grant) begin
      grant_tag = OWNER_DISPLAY;
    end else if (cpu_grant && !i_Cpu_Write_Enable) begin
      grant_tag = OWNER_CPU;
    end else begin
      grant_tag = OWNER_NONE;
    end
  end

  // Streak: counts display wins while the CPU is waiting, saturating.
  always_comb begin
    streak_d = streak_q;
    if (!i_Cpu_Valid || cpu_grant) begin
      streak_d = '0;
    end else if (display_grant && (streak_q < STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Next RAM command; address and write data hold when idle.
  always_comb begin
    ram_en_d    = display_grant || cpu_grant;
    ram_we_d    = cpu_grant && i_Cpu_Write_Enable;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (display_grant) begin
      ram_addr_d = i_Display_Request_Address;
    end else if (cpu_grant) begin
      ram_addr_d  = i_Cpu_Address;
      ram_wdata_d = i_Cpu_Write_Data;
    end
  end

  // Streak and RAM command registers.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      streak_q    <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      streak_q    <= streak_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Drive the RAM command bus from the registers.
  always_comb begin
    o_Ram_Enable       = ram_en_q;
    o_Ram_Write_Enable = ram_we_q;
    o_Ram_Address      = ram_addr_q;
    o_Ram_Write_Data   = ram_wdata_q;
  end

  vram_response_pipe #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_response_pipe (
    .i_Clock              (i_Clock),
    .i_Reset              (i_Reset),
    .i_Tag                (grant_tag),
    .i_Ram_Read_Data      (i_Ram_Read_Data),
    .o_Display_Read_Valid (o_Display_Read_Valid),
    .o_Display_Read_Data  (o_Display_Read_Data),
    .o_Cpu_Read_Valid     (o_Cpu_Read_Valid),
    .o_Cpu_Read_Data      (o_Cpu_Read_Data)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed steps plus a short random phase, with a
// behavioural RAM and a response scoreboard.
module tb_vram_arbiter;

  localparam int AW = 17;
  localparam int DW = 3;
  localparam int EW = 16 + 2 + DW;

  // ---------------- clock / reset ----------------
  logic i_Clock = 1'b0;
  logic i_Reset;
  always #5 i_Clock = ~i_Clock;

  int cyc = 0;
  always @(posedge i_Clock) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          dv, cv, cwe;
  logic [AW-1:0] daddr, caddr;
  logic [DW-1:0] cwd;
  logic          d_ready, c_ready, d_rv, c_rv;
  logic [DW-1:0] d_rd, c_rd;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wd;
  logic [DW-1:0] ram_rd;

  logic          a_d_ready, a_c_ready, a_d_rv, a_c_rv;
  logic [DW-1:0] a_d_rd, a_c_rd;
  logic          a_ram_en, a_ram_we;
  logic [AW-1:0] a_ram_addr;
  logic [DW-1:0] a_ram_wd;

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DISPLAY_STREAK(8)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset),
    .i_Display_Request_Valid(dv), .i_Display_Request_Address(daddr),
    .o_Display_Request_Ready(d_ready),
    .o_Display_Read_Valid(d_rv), .o_Display_Read_Data(d_rd),
    .i_Cpu_Valid(cv), .i_Cpu_Write_Enable(cwe), .i_Cpu_Address(caddr),
    .i_Cpu_Write_Data(cwd), .o_Cpu_Ready(c_ready),
    .o_Cpu_Read_Valid(c_rv), .o_Cpu_Read_Data(c_rd),
    .o_Ram_Enable(ram_en), .o_Ram_Write_Enable(ram_we),
    .o_Ram_Address(ram_addr), .o_Ram_Write_Data(ram_wd),
    .i_Ram_Read_Data(ram_rd)
  );

  // Second instance with a streak of one, only its grants are checked.
  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DISPLAY_STREAK(1)) dut_alt (
    .i_Clock(i_Clock), .i_Reset(i_Reset),
    .i_Display_Request_Valid(dv), .i_Display_Request_Address(daddr),
    .o_Display_Request_Ready(a_d_ready),
    .o_Display_Read_Valid(a_d_rv), .o_Display_Read_Data(a_d_rd),
    .i_Cpu_Valid(cv), .i_Cpu_Write_Enable(cwe), .i_Cpu_Address(caddr),
    .i_Cpu_Write_Data(cwd), .o_Cpu_Ready(a_c_ready),
    .o_Cpu_Read_Valid(a_c_rv), .o_Cpu_Read_Data(a_c_rd),
    .o_Ram_Enable(a_ram_en), .o_Ram_Write_Enable(a_ram_we),
    .o_Ram_Address(a_ram_addr), .o_Ram_Write_Data(a_ram_wd),
    .i_Ram_Read_Data(ram_rd)
  );

  // ---------------- RAM model and shadow ----------------
  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  always @(posedge i_Clock) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wd;
      else        ram_rd <= mem[ram_addr];
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard entries: {accept cycle, owner (1 display, 2 cpu), data}.
  logic [EW-1:0] exp_q[$];

  // Record accepts, update the shadow for writes, compare returned reads.
  always @(negedge i_Clock) begin
    logic [EW-1:0] e, o;
    if (i_Reset) begin
      exp_q.delete();
    end else begin
      if (d_rv || c_rv) begin
        check("valid_overlap", {31'd0, d_rv & c_rv}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_read_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          o = {16'(cyc - 2), (d_rv ? 2'd1 : 2'd2), (d_rv ? d_rd : c_rd)};
          check("response", 32'(o), 32'(e));
        end
      end
      if (dv && d_ready) exp_q.push_back({16'(cyc), 2'd1, shadow[daddr]});
      if (cv && c_ready) begin
        if (cwe) shadow[caddr] = cwd;
        else     exp_q.push_back({16'(cyc), 2'd2, shadow[caddr]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic idle();
    dv = 1'b0; cv = 1'b0; cwe = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_d_ready"},  32'(d_ready),  32'd0);
    check({tag, "_c_ready"},  32'(c_ready),  32'd0);
    check({tag, "_d_rv"},     32'(d_rv),     32'd0);
    check({tag, "_d_rd"},     32'(d_rd),     32'd0);
    check({tag, "_c_rv"},     32'(c_rv),     32'd0);
    check({tag, "_c_rd"},     32'(c_rd),     32'd0);
    check({tag, "_ram_en"},   32'(ram_en),   32'd0);
    check({tag, "_ram_we"},   32'(ram_we),   32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_wd"},   32'(ram_wd),   32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic d_acc, c_acc;
    i_Reset = 1'b1;
    idle();
    daddr = '0; caddr = '0; cwd = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = DW'(i * 5 + 1);
      shadow[i] = DW'(i * 5 + 1);
    end
    mem[17'h00010] = 3'b110; shadow[17'h00010] = 3'b110;
    mem[17'h00100] = 3'b011; shadow[17'h00100] = 3'b011;
    mem[17'h00200] = 3'b100; shadow[17'h00200] = 3'b100;
    mem[17'h00300] = 3'b001; shadow[17'h00300] = 3'b001;
    mem[17'h00400] = 3'b111; shadow[17'h00400] = 3'b111;

    #2;
    check_all_zero("por");
    repeat (2) step();
    i_Reset = 1'b0;
    step();

    // Display read at 0x00010.
    dv = 1'b1; daddr = 17'h00010;
    @(negedge i_Clock);
    check("drd_d_ready", 32'(d_ready), 32'd1);
    check("drd_c_ready", 32'(c_ready), 32'd0);
    step(); idle();
    @(negedge i_Clock);
    check("drd_ram_en",   32'(ram_en),   32'd1);
    check("drd_ram_we",   32'(ram_we),   32'd0);
    check("drd_ram_addr", 32'(ram_addr), 32'h00010);
    step();
    @(negedge i_Clock);
    check("drd_d_rv", 32'(d_rv), 32'd1);
    check("drd_d_rd", 32'(d_rd), 32'b110);
    check("drd_c_rv", 32'(c_rv), 32'd0);
    step();
    @(negedge i_Clock);
    check("drd_d_rv_off",  32'(d_rv),     32'd0);
    check("drd_d_rd_off",  32'(d_rd),     32'd0);
    check("drd_ram_idle",  32'(ram_en),   32'd0);
    check("drd_addr_hold", 32'(ram_addr), 32'h00010);

    // CPU write then read at the top address.
    step();
    cv = 1'b1; cwe = 1'b1; caddr = 17'h1FFFF; cwd = 3'b101;
    @(negedge i_Clock);
    check("cwr_c_ready", 32'(c_ready), 32'd1);
    check("cwr_d_ready", 32'(d_ready), 32'd0);
    step(); idle();
    @(negedge i_Clock);
    check("cwr_ram_en",   32'(ram_en),   32'd1);
    check("cwr_ram_we",   32'(ram_we),   32'd1);
    check("cwr_ram_addr", 32'(ram_addr), 32'h1FFFF);
    check("cwr_ram_wd",   32'(ram_wd),   32'b101);
    step();
    @(negedge i_Clock);
    check("cwr_we_off", 32'(ram_we), 32'd0);
    check("cwr_c_rv",   32'(c_rv),   32'd0);
    check("cwr_d_rv",   32'(d_rv),   32'd0);
    step();
    cv = 1'b1; cwe = 1'b0;
    @(negedge i_Clock);
    check("crd_c_ready", 32'(c_ready), 32'd1);
    step(); idle();
    @(negedge i_Clock);
    check("crd_ram_we", 32'(ram_we), 32'd0);
    check("crd_c_rv_early", 32'(c_rv), 32'd0);
    step();
    @(negedge i_Clock);
    check("crd_c_rv", 32'(c_rv), 32'd1);
    check("crd_c_rd", 32'(c_rd), 32'b101);
    step();

    // Contention: both valid for 27 cycles.
    dv = 1'b1; daddr = 17'h00040; cv = 1'b1; cwe = 1'b0; caddr = 17'h00080;
    for (int k = 1; k <= 27; k++) begin
      @(negedge i_Clock);
      check("cont_c_ready",     32'(c_ready),   32'((k % 9) == 0));
      check("cont_d_ready",     32'(d_ready),   32'((k % 9) != 0));
      check("cont_alt_c_ready", 32'(a_c_ready), 32'((k % 2) == 0));
      step();
    end
    idle();
    repeat (3) step();

    // Alternating owners on consecutive cycles.
    dv = 1'b1; daddr = 17'h00100;
    @(negedge i_Clock);
    check("alt0_d_ready", 32'(d_ready), 32'd1);
    step(); idle(); cv = 1'b1; caddr = 17'h00200;
    @(negedge i_Clock);
    check("alt1_c_ready", 32'(c_ready), 32'd1);
    step(); idle(); dv = 1'b1; daddr = 17'h00300;
    @(negedge i_Clock);
    check("alt2_d_ready", 32'(d_ready), 32'd1);
    check("alt2_d_rv", 32'(d_rv), 32'd1);
    check("alt2_d_rd", 32'(d_rd), 32'b011);
    check("alt2_c_rv", 32'(c_rv), 32'd0);
    step(); idle(); cv = 1'b1; caddr = 17'h00400;
    @(negedge i_Clock);
    check("alt3_c_ready", 32'(c_ready), 32'd1);
    check("alt3_c_rv", 32'(c_rv), 32'd1);
    check("alt3_c_rd", 32'(c_rd), 32'b100);
    check("alt3_d_rv", 32'(d_rv), 32'd0);
    step(); idle();
    @(negedge i_Clock);
    check("alt4_d_rv", 32'(d_rv), 32'd1);
    check("alt4_d_rd", 32'(d_rd), 32'b001);
    check("alt4_c_rv", 32'(c_rv), 32'd0);
    step();
    @(negedge i_Clock);
    check("alt5_c_rv", 32'(c_rv), 32'd1);
    check("alt5_c_rd", 32'(c_rd), 32'b111);
    check("alt5_d_rv", 32'(d_rv), 32'd0);
    step();

    // Reset asserted mid-cycle with both valids high.
    dv = 1'b1; daddr = 17'h00155; cv = 1'b1; cwe = 1'b1; caddr = 17'h000AA; cwd = 3'b111;
    step();
    check("pre_rst_ram_en", 32'(ram_en), 32'd1);
    #2 i_Reset = 1'b1;
    #1 check_all_zero("rst");
    step();
    i_Reset = 1'b0;
    @(negedge i_Clock);
    check("rst_first_d_ready", 32'(d_ready), 32'd1);
    check("rst_first_c_ready", 32'(c_ready), 32'd0);
    step(); idle();
    repeat (3) step();

    // Reset while a CPU read is in flight.
    cv = 1'b1; cwe = 1'b0; caddr = 17'h1FFFF;
    @(negedge i_Clock);
    check("flight_c_ready", 32'(c_ready), 32'd1);
    step(); idle();
    i_Reset = 1'b1;
    #1 check("flight_streak", 32'(dut.streak_q), 32'd0);
    step();
    i_Reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_Clock);
      check("flight_no_c_rv", 32'(c_rv), 32'd0);
      step();
    end

    // Random traffic obeying hold-until-accepted.
    d_acc = 1'b1; c_acc = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (!dv || d_acc) begin
        dv = 1'($urandom_range(0, 1));
        daddr = AW'($urandom_range(0, 1023));
      end
      if (!cv || c_acc) begin
        cv = 1'($urandom_range(0, 1));
        cwe = 1'($urandom_range(0, 1));
        caddr = AW'($urandom_range(0, 1023));
        cwd = DW'($urandom_range(0, 7));
      end
      @(negedge i_Clock);
      check("rand_one_ready", 32'(d_ready & c_ready), 32'd0);
      d_acc = dv & d_ready;
      c_acc = cv & c_ready;
      step();
    end
    idle();
    repeat (4) step();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
